// File: rtl/chan_dispatch.sv
// chan_dispatch: routes the single host channel of comm_fpga_epp to NUM_PORTS
// application endpoints. Host writes pass through a 2-entry FIFO. On a channel
// change the pipe closes until the FIFO has drained to the old endpoint.
// Host reads are combinational and are never buffered.
// Optional feature macro: CHAN_STATS_EN adds per-port saturating write counters,
// which are read back through STATS_CHAN.
module chan_dispatch #(
    parameter int NUM_PORTS  = 4,
    parameter int BASE_CHAN  = 0,
    parameter int STATS_CHAN = 127
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [6:0]             chanAddr_in,
    input  logic [7:0]             h2fData_in,
    input  logic                   h2fValid_in,
    output logic                   h2fReady_out,
    output logic [7:0]             f2hData_out,
    output logic                   f2hValid_out,
    input  logic                   f2hReady_in,
    output logic [8*NUM_PORTS-1:0] portH2fData_out,
    output logic [NUM_PORTS-1:0]   portH2fValid_out,
    input  logic [NUM_PORTS-1:0]   portH2fReady_in,
    input  logic [8*NUM_PORTS-1:0] portF2hData_in,
    input  logic [NUM_PORTS-1:0]   portF2hValid_in,
    output logic [NUM_PORTS-1:0]   portF2hReady_out
);

    localparam int         SEL_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [7:0] BASE_LO    = 8'(BASE_CHAN);
    localparam logic [7:0] NPORTS8    = 8'(NUM_PORTS);
    localparam logic [6:0] STATS_ADDR = 7'(STATS_CHAN);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    state_e             state_q;
    logic [6:0]         curAddr_q;
    logic [1:0]         count_q, count_d;
    logic [7:0]         slot0_q, slot0_d;
    logic [7:0]         slot1_q, slot1_d;

    logic [8:0]         off9;
    logic               in_range;
    logic               sel_vld;
    logic [SEL_W-1:0]   sel;
    logic               sel_rdy;
    logic               match;
    logic               open;
    logic               push;
    logic               pop;

    // Port decode: a borrow out of the subtraction means the address is below the base
    assign off9     = {2'b00, curAddr_q} - {1'b0, BASE_LO};
    assign in_range = !off9[8] && (off9[7:0] < NPORTS8);
    assign sel_vld  = in_range && (curAddr_q != STATS_ADDR);
    assign sel      = off9[SEL_W-1:0];

    assign match        = (chanAddr_in == curAddr_q);
    assign open         = (state_q == ST_RUN) && match;
    assign h2fReady_out = open && (count_q != 2'd2);
    assign push         = h2fValid_in && h2fReady_out;
    // Unselected addresses act as a write sink: the head is dropped every cycle
    assign pop          = (count_q != 2'd0) && (sel_vld ? sel_rdy : 1'b1);

`ifdef CHAN_STATS_EN
    logic             is_stats;
    logic             stats_rd;
    logic [7:0]       cnt_q [NUM_PORTS];
    logic [SEL_W-1:0] ptr_q;
    logic [7:0]       stats_byte;

    assign is_stats = (curAddr_q == STATS_ADDR);
    assign stats_rd = open && is_stats && f2hReady_in;

    // Per-port write counters; a byte written to the stats channel clears them all
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= 8'h00;
            ptr_q <= '0;
        end else if (pop && is_stats) begin
            for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= 8'h00;
            ptr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (pop && sel_vld && (sel == SEL_W'(i)) && (cnt_q[i] != 8'hFF))
                    cnt_q[i] <= cnt_q[i] + 8'd1;
            end
            if (stats_rd)
                ptr_q <= (ptr_q == SEL_W'(NUM_PORTS - 1)) ? '0 : ptr_q + SEL_W'(1);
        end
    end

    // Counter selected by the read pointer
    always_comb begin
        stats_byte = 8'h00;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ptr_q == SEL_W'(i)) stats_byte = cnt_q[i];
        end
    end
`endif

    // Channel FSM: close on mismatch, drain old bytes, then latch the new address
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= ST_SWITCH;
            curAddr_q <= 7'd0;
        end else begin
            case (state_q)
                ST_SWITCH: begin
                    curAddr_q <= chanAddr_in;
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    if (!match) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (count_q == 2'd0) state_q <= ST_SWITCH;
                end
                default: state_q <= ST_SWITCH;
            endcase
        end
    end

    // FIFO next state: slot0 is always the head, slot1 the second entry
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) slot0_d = h2fData_in;
                else                 slot1_d = h2fData_in;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = h2fData_in;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = h2fData_in;
                end
            end
            default: ;
        endcase
    end

    // FIFO occupancy; anything in flight at reset is discarded
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) count_q <= 2'd0;
        else           count_q <= count_d;
    end

    // FIFO storage needs no reset; outputs are gated by the occupancy
    always_ff @(posedge clk_in) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    // Steer the FIFO head to the selected port; other ports stay idle
    always_comb begin
        portH2fData_out  = '0;
        portH2fValid_out = '0;
        sel_rdy          = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_vld && (sel == SEL_W'(i))) begin
                portH2fValid_out[i]       = (count_q != 2'd0);
                portH2fData_out[8*i +: 8] = (count_q != 2'd0) ? slot0_q : 8'h00;
                sel_rdy                   = portH2fReady_in[i];
            end
        end
    end

    // Read path: straight through to the selected port, zero source otherwise
    always_comb begin
        f2hValid_out     = 1'b0;
        f2hData_out      = 8'h00;
        portF2hReady_out = '0;
        if (open) begin
            if (sel_vld) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (sel == SEL_W'(i)) begin
                        f2hValid_out        = portF2hValid_in[i];
                        f2hData_out         = portF2hValid_in[i] ? portF2hData_in[8*i +: 8] : 8'h00;
                        portF2hReady_out[i] = f2hReady_in;
                    end
                end
            end else begin
                f2hValid_out = 1'b1;
`ifdef CHAN_STATS_EN
                if (is_stats) f2hData_out = stats_byte;
`endif
            end
        end
    end

endmodule

// File: tb/tb_chan_dispatch.sv
// Testbench for chan_dispatch with a queue-based routing model.
module tb_chan_dispatch;

    localparam int NP    = 4;
    localparam int BASE  = 0;
    localparam int STATS = 127;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    chanAddr;
    logic [7:0]    h2fData;
    logic          h2fValid;
    logic          h2fReady;
    logic [7:0]    f2hData;
    logic          f2hValid;
    logic          f2hReady;
    logic [8*NP-1:0] pH2fData;
    logic [NP-1:0] pH2fValid;
    logic [NP-1:0] pH2fReady;
    logic [8*NP-1:0] pF2hData;
    logic [NP-1:0] pF2hValid;
    logic [NP-1:0] pF2hReady;

    int checks = 0;
    int errors = 0;

    // Model: bytes accepted while the host selected channel c belong to port c
    logic [7:0] exp_q [NP][$];
    logic [7:0] obs_q [NP][$];
    int         acc_cnt;
    logic       last_acc;

    always #5 clk = ~clk;

    chan_dispatch #(.NUM_PORTS(NP), .BASE_CHAN(BASE), .STATS_CHAN(STATS)) dut (
        .clk_in           (clk),
        .reset_in         (rst_n),
        .chanAddr_in      (chanAddr),
        .h2fData_in       (h2fData),
        .h2fValid_in      (h2fValid),
        .h2fReady_out     (h2fReady),
        .f2hData_out      (f2hData),
        .f2hValid_out     (f2hValid),
        .f2hReady_in      (f2hReady),
        .portH2fData_out  (pH2fData),
        .portH2fValid_out (pH2fValid),
        .portH2fReady_in  (pH2fReady),
        .portF2hData_in   (pF2hData),
        .portF2hValid_in  (pF2hValid),
        .portF2hReady_out (pF2hReady)
    );

    function automatic bit in_rng(input int a);
        return (a >= BASE) && (a < BASE + NP);
    endfunction

    task automatic clear_logs();
        for (int p = 0; p < NP; p++) begin
            exp_q[p].delete();
            obs_q[p].delete();
        end
        acc_cnt = 0;
    endtask

    // Observe this cycle's handshakes, then advance to the next negedge
    task automatic tick();
        int c;
        #1;
        c = int'(chanAddr);
        last_acc = h2fValid && h2fReady;
        if (last_acc) begin
            acc_cnt++;
            if (in_rng(c)) exp_q[c - BASE].push_back(h2fData);
        end
        for (int p = 0; p < NP; p++)
            if (pH2fValid[p] && pH2fReady[p]) obs_q[p].push_back(pH2fData[8*p +: 8]);
        @(negedge clk);
    endtask

    // Waits until the pipe is open; returns at negedge+1 with inputs untouched
    task automatic wait_open(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (h2fReady) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic send_n(input int n, output int sent);
        sent = 0;
        for (int i = 0; (i < 2*n + 20) && (sent < n); i++) begin
            h2fValid = 1'b1;
            h2fData  = 8'(sent);
            tick();
            if (last_acc) sent++;
        end
        h2fValid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; chanAddr = 7'd1; h2fValid = 1'b1; h2fData = 8'h5A;
        pH2fReady = '1; pF2hValid = '1; pF2hData = 32'hDEADBEEF; f2hReady = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (h2fReady !== 1'b0) begin errors++; $display("FAIL rst_h2fReady got %0h want 0", h2fReady); end
        checks++; if (f2hValid !== 1'b0) begin errors++; $display("FAIL rst_f2hValid got %0h want 0", f2hValid); end
        checks++; if (f2hData !== 8'h00) begin errors++; $display("FAIL rst_f2hData got %0h want 0", f2hData); end
        checks++; if (pH2fValid !== '0) begin errors++; $display("FAIL rst_pH2fValid got %0h want 0", pH2fValid); end
        checks++; if (pF2hReady !== '0) begin errors++; $display("FAIL rst_pF2hReady got %0h want 0", pF2hReady); end
        checks++; if (pH2fData !== '0) begin errors++; $display("FAIL rst_pH2fData got %0h want 0", pH2fData); end
    endtask

    task automatic test_first_write();
        @(negedge clk);
        clear_logs();
        rst_n = 1'b1; chanAddr = 7'd1; h2fValid = 1'b1; h2fData = 8'hA5;
        pF2hValid = '0; f2hReady = 1'b0;
        #1;
        checks++; if (h2fReady !== 1'b0) begin errors++; $display("FAIL switch_cycle_ready got %0h want 0", h2fReady); end
        tick();
        #1;
        checks++; if (h2fReady !== 1'b1) begin errors++; $display("FAIL first_open_ready got %0h want 1", h2fReady); end
        tick();
        h2fValid = 1'b0;
        #1;
        checks++; if (pH2fValid !== 4'b0010) begin errors++; $display("FAIL first_valid got %0h want 2", pH2fValid); end
        checks++; if (pH2fData[15:8] !== 8'hA5) begin errors++; $display("FAIL first_data got %0h want a5", pH2fData[15:8]); end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] want [3];
        bit bad;
        want = '{8'h01, 8'h02, 8'h03};
        clear_logs();
        h2fValid = 1'b0; pH2fReady = 4'b1011; chanAddr = 7'd2;
        wait_open(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_open got 0 want 1"); end
        h2fValid = 1'b1; h2fData = 8'h01;
        #1;
        checks++; if (h2fReady !== 1'b1) begin errors++; $display("FAIL bp_acc1 got %0h want 1", h2fReady); end
        tick();
        h2fData = 8'h02;
        #1;
        checks++; if (h2fReady !== 1'b1) begin errors++; $display("FAIL bp_acc2 got %0h want 1", h2fReady); end
        tick();
        h2fData = 8'h03;
        #1;
        checks++; if (h2fReady !== 1'b0) begin errors++; $display("FAIL bp_full got %0h want 0", h2fReady); end
        checks++; if (pH2fValid !== 4'b0100 || pH2fData[23:16] !== 8'h01) begin
            errors++; $display("FAIL bp_head got v=%0h d=%0h want v=4 d=01", pH2fValid, pH2fData[23:16]); end
        tick();
        tick();
        #1;
        checks++; if (h2fReady !== 1'b0) begin errors++; $display("FAIL bp_still_full got %0h want 0", h2fReady); end
        pH2fReady = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_acc) h2fValid = 1'b0;
        end
        bad = (obs_q[2].size() != 3);
        if (!bad) for (int k = 0; k < 3; k++) if (obs_q[2][k] !== want[k]) bad = 1'b1;
        checks++; if (bad) begin errors++; $display("FAIL bp_order got %0d bytes want 01 02 03", obs_q[2].size()); end
    endtask

    task automatic test_switch_drain();
        bit ok;
        int acc_cyc, last_pop;
        bit bad;
        clear_logs();
        h2fValid = 1'b0; pH2fReady = 4'b1110; chanAddr = 7'd0;
        wait_open(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sw_open got 0 want 1"); end
        h2fValid = 1'b1; h2fData = 8'h10;
        tick();
        h2fData = 8'h11;
        tick();
        h2fData = 8'h30; chanAddr = 7'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (h2fReady !== 1'b0) begin errors++; $display("FAIL sw_blocked%0d got %0h want 0", i, h2fReady); end
            tick();
        end
        pH2fReady = 4'b1111;
        acc_cyc = -1; last_pop = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (pH2fValid[0] && pH2fReady[0]) last_pop = c;
            if (h2fReady && h2fValid && acc_cyc < 0) acc_cyc = c;
            tick();
            if (last_acc) h2fValid = 1'b0;
        end
        checks++; if (last_pop != 1) begin errors++; $display("FAIL sw_last_pop got %0d want 1", last_pop); end
        checks++; if (acc_cyc != 4) begin errors++; $display("FAIL sw_new_accept got %0d want 4", acc_cyc); end
        bad = (obs_q[0].size() != 2);
        if (!bad) bad = (obs_q[0][0] !== 8'h10) || (obs_q[0][1] !== 8'h11);
        checks++; if (bad) begin errors++; $display("FAIL sw_old_port got %0d bytes want 10 11", obs_q[0].size()); end
        bad = (obs_q[3].size() != 1);
        if (!bad) bad = (obs_q[3][0] !== 8'h30);
        checks++; if (bad) begin errors++; $display("FAIL sw_new_port got %0d bytes want 30", obs_q[3].size()); end
    endtask

    task automatic test_sink();
        bit ok;
        int tot;
        clear_logs();
        h2fValid = 1'b0; chanAddr = 7'd100;
        wait_open(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sink_open got 0 want 1"); end
        for (int i = 0; i < 4; i++) begin
            h2fValid = 1'b1; h2fData = 8'(8'h40 + i);
            #1;
            checks++; if (h2fReady !== 1'b1) begin errors++; $display("FAIL sink_ready%0d got %0h want 1", i, h2fReady); end
            checks++; if (pH2fValid !== '0) begin errors++; $display("FAIL sink_novalid%0d got %0h want 0", i, pH2fValid); end
            tick();
        end
        h2fValid = 1'b0; f2hReady = 1'b1; pF2hValid = '1;
        for (int i = 0; i < 3; i++) begin
            pF2hData = $urandom;
            #1;
            checks++; if (f2hValid !== 1'b1 || f2hData !== 8'h00) begin
                errors++; $display("FAIL sink_read%0d got v=%0h d=%0h want v=1 d=00", i, f2hValid, f2hData); end
            checks++; if (pF2hReady !== '0) begin errors++; $display("FAIL sink_rdready%0d got %0h want 0", i, pF2hReady); end
            tick();
        end
        tot = 0;
        for (int p = 0; p < NP; p++) tot += obs_q[p].size();
        checks++; if (tot != 0) begin errors++; $display("FAIL sink_leak got %0d want 0", tot); end
    endtask

    task automatic test_read();
        bit ok;
        logic [7:0] b2;
        f2hReady = 1'b0; pF2hValid = '0; chanAddr = 7'd1;
        wait_open(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rd_open got 0 want 1"); end
        pF2hData = $urandom; pF2hData[15:8] = 8'h3C; pF2hValid = 4'b0010; f2hReady = 1'b1;
        #1;
        checks++; if (f2hValid !== 1'b1 || f2hData !== 8'h3C) begin
            errors++; $display("FAIL rd_data got v=%0h d=%0h want v=1 d=3c", f2hValid, f2hData); end
        checks++; if (pF2hReady !== 4'b0010) begin errors++; $display("FAIL rd_ready got %0h want 2", pF2hReady); end
        tick();
        f2hReady = 1'b0;
        #1;
        checks++; if (pF2hReady !== 4'b0000 || f2hValid !== 1'b1) begin
            errors++; $display("FAIL rd_hold got r=%0h v=%0h want r=0 v=1", pF2hReady, f2hValid); end
        tick();
        pF2hValid = 4'b1101; f2hReady = 1'b1;
        #1;
        checks++; if (f2hValid !== 1'b0 || f2hData !== 8'h00) begin
            errors++; $display("FAIL rd_empty got v=%0h d=%0h want v=0 d=00", f2hValid, f2hData); end
        tick();
        pF2hValid = 4'b1111; chanAddr = 7'd2;
        #1;
        checks++; if (f2hValid !== 1'b0 || pF2hReady !== '0) begin
            errors++; $display("FAIL rd_mismatch got v=%0h r=%0h want v=0 r=0", f2hValid, pF2hReady); end
        tick();
        wait_open(10, ok);
        b2 = pF2hData[23:16];
        checks++; if (!ok || f2hData !== b2 || pF2hReady !== 4'b0100) begin
            errors++; $display("FAIL rd_newchan got d=%0h r=%0h want d=%0h r=4", f2hData, pF2hReady, b2); end
        tick();
        f2hReady = 1'b0; pF2hValid = '0;
    endtask

    task automatic test_async_reset();
        bit ok;
        h2fValid = 1'b0; chanAddr = 7'd2; pH2fReady = 4'b1011;
        wait_open(10, ok);
        h2fValid = 1'b1; h2fData = 8'h77;
        tick();
        h2fValid = 1'b0;
        #1;
        checks++; if (pH2fValid !== 4'b0100) begin errors++; $display("FAIL ar_buffered got %0h want 4", pH2fValid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (pH2fValid !== '0 || h2fReady !== 1'b0) begin
            errors++; $display("FAIL ar_async got v=%0h r=%0h want 0 0", pH2fValid, h2fReady); end
        @(negedge clk);
        rst_n = 1'b1; pH2fReady = '1;
        clear_logs();
        repeat (6) tick();
        checks++; if (obs_q[2].size() != 0) begin errors++; $display("FAIL ar_discard got %0d want 0", obs_q[2].size()); end
    endtask

    task automatic test_random();
        logic [6:0] chans [5];
        int c;
        logic [3:0] oh;
        bit bad;
        chans = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd100};
        clear_logs();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if ($urandom_range(0, 15) == 0) chanAddr = chans[$urandom_range(0, 4)];
            h2fValid = 1'($urandom_range(0, 1)); h2fData = 8'($urandom);
            pH2fReady = 4'($urandom); pF2hValid = 4'($urandom); pF2hData = $urandom;
            f2hReady = 1'($urandom_range(0, 1));
            #1;
            c = int'(chanAddr);
            checks++; if ($countones(pH2fValid) > 1) begin errors++; $display("FAIL rnd_onehot cyc %0d got %0h want <=1 bit", cyc, pH2fValid); end
            if (in_rng(c)) begin
                oh = 4'b0001 << (c - BASE);
                checks++; if ((pF2hReady & ~oh) !== '0) begin errors++; $display("FAIL rnd_rd_stray cyc %0d got %0h want subset of %0h", cyc, pF2hReady, oh); end
                if (f2hValid) begin
                    checks++; if (!pF2hValid[c-BASE] || f2hData !== pF2hData[8*(c-BASE) +: 8] || pF2hReady !== (f2hReady ? oh : 4'b0000)) begin
                        errors++; $display("FAIL rnd_read cyc %0d got d=%0h r=%0h want d=%0h", cyc, f2hData, pF2hReady, pF2hData[8*(c-BASE) +: 8]); end
                end
            end else begin
                checks++; if (pF2hReady !== '0 || (f2hValid && f2hData !== 8'h00)) begin
                    errors++; $display("FAIL rnd_sink_read cyc %0d got d=%0h r=%0h want d=00 r=0", cyc, f2hData, pF2hReady); end
            end
            if (!f2hValid) begin
                checks++; if (f2hData !== 8'h00) begin errors++; $display("FAIL rnd_idle_data cyc %0d got %0h want 00", cyc, f2hData); end
            end
            tick();
        end
        h2fValid = 1'b0; pH2fReady = '1;
        repeat (10) tick();
        for (int p = 0; p < NP; p++) begin
            bad = (obs_q[p].size() != exp_q[p].size());
            if (!bad) for (int k = 0; k < exp_q[p].size(); k++) if (obs_q[p][k] !== exp_q[p][k]) bad = 1'b1;
            checks++; if (bad) begin
                errors++; $display("FAIL rnd_port%0d_stream got %0d bytes want %0d in order", p, obs_q[p].size(), exp_q[p].size()); end
        end
    endtask

    task automatic test_stats();
        bit ok;
        int sent;
        pH2fReady = '1; h2fValid = 1'b0; f2hReady = 1'b0; chanAddr = 7'(STATS);
        wait_open(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL st_open got 0 want 1"); end
`ifdef CHAN_STATS_EN
        h2fValid = 1'b1; h2fData = 8'h00;
        tick();
        h2fValid = 1'b0;
        repeat (2) tick();
        chanAddr = 7'd0;
        wait_open(10, ok);
        send_n(5, sent);
        checks++; if (sent != 5) begin errors++; $display("FAIL st_send0 got %0d want 5", sent); end
        chanAddr = 7'd1;
        wait_open(10, ok);
        send_n(300, sent);
        checks++; if (sent != 300) begin errors++; $display("FAIL st_send1 got %0d want 300", sent); end
        chanAddr = 7'(STATS);
        wait_open(10, ok);
        tick();
        f2hReady = 1'b1;
        #1;
        checks++; if (f2hValid !== 1'b1 || f2hData !== 8'h05) begin
            errors++; $display("FAIL st_cnt0 got v=%0h d=%0h want v=1 d=05", f2hValid, f2hData); end
        tick();
        #1;
        checks++; if (f2hData !== 8'hFF) begin errors++; $display("FAIL st_cnt1_sat got %0h want ff", f2hData); end
        tick();
        f2hReady = 1'b0; h2fValid = 1'b1; h2fData = 8'h99;
        tick();
        h2fValid = 1'b0;
        tick();
        f2hReady = 1'b1;
        #1;
        checks++; if (f2hValid !== 1'b1 || f2hData !== 8'h00) begin
            errors++; $display("FAIL st_cleared got v=%0h d=%0h want v=1 d=00", f2hValid, f2hData); end
        checks++; if (pH2fValid !== '0) begin errors++; $display("FAIL st_not_forwarded got %0h want 0", pH2fValid); end
        tick();
`else
        f2hReady = 1'b1; pF2hValid = '1; pF2hData = $urandom; h2fValid = 1'b1; h2fData = 8'h99;
        #1;
        checks++; if (f2hValid !== 1'b1 || f2hData !== 8'h00) begin
            errors++; $display("FAIL st_plain_read got v=%0h d=%0h want v=1 d=00", f2hValid, f2hData); end
        checks++; if (h2fReady !== 1'b1) begin errors++; $display("FAIL st_plain_sink got %0h want 1", h2fReady); end
        tick();
        h2fValid = 1'b0;
        #1;
        checks++; if (pH2fValid !== '0) begin errors++; $display("FAIL st_plain_novalid got %0h want 0", pH2fValid); end
        tick();
`endif
        f2hReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_backpressure();
        test_switch_drain();
        test_sink();
        test_read();
        test_async_reset();
        test_random();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/chan_dispatch.md
Name: chan_dispatch

Overview:
- Sits between comm_fpga_epp's single channel interface (chanAddr/h2f/f2h) and NUM_PORTS application endpoints.
- Decodes the host channel address and routes each host write or read to one endpoint.
- Holds the pipe closed while a channel switch is in progress: host writes still buffered for the old endpoint are delivered there before the new endpoint is selected.
- A 2-entry h2f buffer gives a registered break between comm_fpga and the applications.

Parameters:
- NUM_PORTS, 4: number of endpoints, 1..16.
- BASE_CHAN, 0: channel address of port 0. Port i = channel BASE_CHAN+i. BASE_CHAN+NUM_PORTS-1 must be <= 126.
- STATS_CHAN, 127: channel address of the statistics channel (CHAN_STATS_EN only). Must lie outside the port range.

Ports:
- clk_in  in  1  system clock.
- reset_in  in  1  asynchronous, active-low reset.
- chanAddr_in  in  7  host-selected channel.
- h2fData_in  in  8  host write data.
- h2fValid_in  in  1  host write byte valid.
- h2fReady_out  out  1  dispatcher can accept a host byte.
- f2hData_out  out  8  host read data.
- f2hValid_out  out  1  read byte available.
- f2hReady_in  in  1  host consumes the read byte this cycle.
- portH2fData_out  out  8*NUM_PORTS  write data; byte i goes to port i.
- portH2fValid_out  out  NUM_PORTS  per-port write valid.
- portH2fReady_in  in  NUM_PORTS  per-port write ready.
- portF2hData_in  in  8*NUM_PORTS  per-port read data.
- portF2hValid_in  in  NUM_PORTS  per-port read valid.
- portF2hReady_out  out  NUM_PORTS  per-port read ready.

Behaviour:
- Registers:
  - curAddr_q (7 bits).
  - state: RUN, DRAIN or SWITCH.
  - 2-entry h2f FIFO holding data and count (0..2).
  - sel = curAddr_q-BASE_CHAN when in range; otherwise sel = NONE.
- Reset (reset_in=0, asynchronous):
  - state=SWITCH, curAddr_q=0, FIFO count=0.
  - All outputs 0: h2fReady_out, f2hValid_out, f2hData_out, portH2fValid_out, portF2hReady_out. portH2fData_out=0.
  - Bytes in flight when reset asserts are discarded.
- match = (chanAddr_in==curAddr_q). open = (state==RUN) && match.
- State machine:
  - SWITCH: curAddr_q<=chanAddr_in; next state RUN.
  - RUN: if !match, next state DRAIN.
  - DRAIN: when FIFO count==0, next state SWITCH. curAddr_q does not change in DRAIN.
  - Channel change with an empty FIFO: mismatch at cycle t; upstream blocked t..t+2; first accept possible at t+3.
- h2f path:
  - h2fReady_out = open && count<2.
  - Push when h2fValid_in && h2fReady_out.
  - FIFO head drives portH2fData_out[sel]. portH2fValid_out[sel] = (count>0). All other ports: valid 0.
  - Pop when portH2fReady_in[sel] && count>0.
  - sel==NONE: the head is popped every cycle with count>0 (write sink).
  - Simultaneous push and pop: count unchanged, order preserved.
  - Latency: a byte accepted in cycle t is presented to the port in cycle t+1.
- f2h path (combinational, no buffering):
  - f2hValid_out = open && portF2hValid_in[sel].
  - f2hData_out = portF2hData_in[sel] when f2hValid_out=1, else 0x00.
  - portF2hReady_out[sel] = open && f2hReady_in. All other ports 0.
  - sel==NONE and open: f2hValid_out=1, f2hData_out=0x00; reads never stall.
- A chanAddr_in change never drops or misroutes bytes already accepted, and never lets a read complete on the old channel once the mismatch is visible.

Optional Feature:
- Macro: CHAN_STATS_EN.
- When defined:
  - Adds an 8-bit saturating write counter per port, incremented on each FIFO pop to that port. Saturates at 0xFF.
  - Reads of STATS_CHAN return counter[ptr], then ptr increments modulo NUM_PORTS. Reads never stall.
  - Any byte written to STATS_CHAN clears all counters and ptr. The written byte is consumed and not forwarded.
  - Counters and ptr reset to 0.
- When undefined: STATS_CHAN is an ordinary out-of-range address (write sink, reads return 0x00). No counter logic is generated.

Test Plan:
- Reset, then chanAddr=BASE_CHAN+1, write 0xA5 -> portH2fValid_out[1]=1 with data 0xA5 one cycle after the accept; no other port valid; h2fReady_out=0 for exactly the 1 post-reset SWITCH cycle.
- Port 2 holds portH2fReady_in=0; host writes 3 bytes -> 2 accepted, then h2fReady_out=0. Release ready -> 0x01, 0x02, 0x03 delivered in order.
- Port 0 holds ready low with 2 bytes buffered; chanAddr changes to port 3 -> upstream blocked; both bytes reach port 0 after release; port 3 traffic starts 2 cycles after the FIFO empties.
- chanAddr=100 (out of range): write 4 bytes -> all accepted at one per cycle, no port valid; read -> 0x00 every cycle.
- Read port 1 with portF2hData_in=0x3C, valid=1 -> f2hData_out=0x3C the same cycle, portF2hReady_out[1]=f2hReady_in; mid-stream address change -> f2hValid_out=0 in the mismatch cycle.
- CHAN_STATS_EN: 5 writes to port 0 and 300 to port 1; read STATS_CHAN twice -> 0x05, then 0xFF. Write to STATS_CHAN, then read -> 0x00.
